fpga_robots_game_lockmon: RTL and testbench

Clock-lock supervisor for the game's clock domain. Takes any number of asynchronous PLL `LOCKED` indications, synchronises them into the game clock, requires them to be stable for a programmable time, then releases a held game reset after a further hold interval. On any lock loss it re-asserts reset immediately and counts the event. It sits between the clock generator and all game logic, replacing the constant "locked" tie-off.

---
 rtl/fpga_robots_game_lockmon.sv | 136 +++++++++++++
 tb/tb_fpga_robots_game_lockmon.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_robots_game_lockmon.sv
// Clock-lock supervisor: synchronises PLL lock flags, qualifies their stability and sequences the game reset.
// Define FPGA_ROBOTS_GAME_LOCKMON_COUNT_EN to build the saturating lock-loss counter; otherwise loss_count is 0.
module fpga_robots_game_lockmon #(
  parameter int N_LOCKS       = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LOCKS-1:0] locks_async,
  output logic               game_rst,
  output logic               ready,
  output logic [1:0]         state,
  output logic               lock_lost,
  output logic [CNT_W-1:0]   loss_count
);

  localparam logic [1:0] S_WAIT = 2'b00;
  localparam logic [1:0] S_HOLD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [N_LOCKS-1:0] sync_q [SYNC_STAGES];
  logic               all_locked;

  logic [1:0]        state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              loss_event;
  logic              game_rst_q, ready_q, lock_lost_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= locks_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign all_locked = &sync_q[SYNC_STAGES-1];

  // Any unlocked edge outside WAIT is a loss event and restarts qualification from zero.
  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    hold_d     = hold_q;
    loss_event = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (!all_locked) begin
          stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = S_HOLD;
          stab_d  = '0;
          hold_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (!all_locked) begin
          state_d    = S_WAIT;
          loss_event = 1'b1;
          stab_d     = '0;
          hold_d     = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!all_locked) begin
          state_d    = S_WAIT;
          loss_event = 1'b1;
          stab_d     = '0;
          hold_d     = '0;
        end
      end
      default: begin
        state_d = S_WAIT;
        stab_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT;
      stab_q      <= '0;
      hold_q      <= '0;
      game_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_q      <= stab_d;
      hold_q      <= hold_d;
      game_rst_q  <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      lock_lost_q <= loss_event;
    end
  end

  assign state     = state_q;
  assign game_rst  = game_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;

`ifdef FPGA_ROBOTS_GAME_LOCKMON_COUNT_EN
  logic [CNT_W-1:0] loss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if (loss_event && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign loss_count = loss_cnt_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_fpga_robots_game_lockmon.sv
// Bench for fpga_robots_game_lockmon: a default-parameter instance plus a small one (CNT_W=2) for counter saturation.
// Expected outputs come from a locked-streak model: a low edge zeroes the streak, state follows streak thresholds.
module tb_fpga_robots_game_lockmon;

  localparam int STAB_A = 1024, HOLD_A = 16;
  localparam int STAB_B = 4,    HOLD_B = 3;
`ifdef FPGA_ROBOTS_GAME_LOCKMON_COUNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lk_a = 2'b11, lk_b = 2'b11;

  logic       gr_a, rdy_a, ll_a, gr_b, rdy_b, ll_b;
  logic [1:0] st_a, st_b;
  logic [7:0] lc_a;
  logic [1:0] lc_b;

  int n_checks = 0;
  int n_fail   = 0;

  fpga_robots_game_lockmon dut_a (
    .clk(clk), .rst(rst), .locks_async(lk_a),
    .game_rst(gr_a), .ready(rdy_a), .state(st_a), .lock_lost(ll_a), .loss_count(lc_a)
  );

  fpga_robots_game_lockmon #(
    .N_LOCKS(2), .SYNC_STAGES(2), .STABLE_CYCLES(STAB_B), .HOLD_CYCLES(HOLD_B), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .locks_async(lk_b),
    .game_rst(gr_b), .ready(rdy_b), .state(st_b), .lock_lost(ll_b), .loss_count(lc_b)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [1:0] ha0, ha1, hb0, hb1;   // two-edge delay of the sampled lock inputs (ha0 = oldest)
  int sa, sb;                       // consecutive all-locked edges since the last unlocked edge
  int ca, cb;
  logic la_m, lb_m;
  int ec;                           // edges since reset release

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ha0 <= 2'b00; ha1 <= 2'b00; hb0 <= 2'b00; hb1 <= 2'b00;
      sa <= 0; sb <= 0; ca <= 0; cb <= 0; la_m <= 1'b0; lb_m <= 1'b0; ec <= 0;
    end else begin
      ha0 <= ha1; ha1 <= lk_a;
      hb0 <= hb1; hb1 <= lk_b;
      ec  <= ec + 1;
      if (&ha0) sa <= (sa < STAB_A + HOLD_A) ? sa + 1 : sa;
      else      sa <= 0;
      la_m <= !(&ha0) && (sa >= STAB_A);
      if (!(&ha0) && (sa >= STAB_A) && (ca < 255)) ca <= ca + 1;
      if (&hb0) sb <= (sb < STAB_B + HOLD_B) ? sb + 1 : sb;
      else      sb <= 0;
      lb_m <= !(&hb0) && (sb >= STAB_B);
      if (!(&hb0) && (sb >= STAB_B) && (cb < 3)) cb <= cb + 1;
    end
  end

  function automatic logic [1:0] st_of(input int streak, input int stab, input int hold);
    if (streak < stab)             return 2'b00;
    else if (streak < stab + hold) return 2'b01;
    else                           return 2'b10;
  endfunction

  logic [1:0]  sa_e, sb_e;
  logic [7:0]  ca_e;
  logic [1:0]  cb_e;
  logic [19:0] exp_v, act_v;
  assign sa_e  = st_of(sa, STAB_A, HOLD_A);
  assign sb_e  = st_of(sb, STAB_B, HOLD_B);
  assign ca_e  = (CE != 0) ? ca[7:0] : 8'h00;
  assign cb_e  = (CE != 0) ? cb[1:0] : 2'b00;
  assign exp_v = {sa_e != 2'b10, sa_e == 2'b10, sa_e, la_m, ca_e,
                  sb_e != 2'b10, sb_e == 2'b10, sb_e, lb_m, cb_e};
  assign act_v = {gr_a, rdy_a, st_a, ll_a, lc_a, gr_b, rdy_b, st_b, ll_b, lc_b};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int hold_e = -1, run_e = -1;
    rst = 1'b1; lk_a = 2'b11; lk_b = 2'b11;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gr_a, rdy_a, st_a, ll_a, lc_a} !== 13'b1_0_00_0_00000000) begin
      n_fail++; $display("FAIL reset_a act=%b exp=%b", {gr_a, rdy_a, st_a, ll_a, lc_a}, 13'b1_0_00_0_00000000);
    end
    n_checks++;
    if ({gr_b, rdy_b, st_b, ll_b, lc_b} !== 7'b1_0_00_0_00) begin
      n_fail++; $display("FAIL reset_b act=%b exp=%b", {gr_b, rdy_b, st_b, ll_b, lc_b}, 7'b1_0_00_0_00);
    end
    rst = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL reset_seq ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
      if (st_a == 2'b01 && hold_e < 0) hold_e = ec;
      if (st_a == 2'b10 && run_e < 0) begin run_e = ec; break; end
    end
    n_checks++;
    if (hold_e != 1026) begin n_fail++; $display("FAIL reset_hold_edge act=%0d exp=1026", hold_e); end
    n_checks++;
    if (run_e != 1042) begin n_fail++; $display("FAIL reset_run_edge act=%0d exp=1042", run_e); end
  endtask

  task automatic test_wait_glitch();
    int c, bit_i, len, r, run_e = -1;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    c     = $urandom_range(400, 600);
    bit_i = $urandom_range(0, 1);
    len   = $urandom_range(1, 5);
    for (int i = 0; i < 700 && ec < c + 2; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL glitch_pre ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
    end
    lk_a[bit_i] = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL glitch_low ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
    end
    lk_a = 2'b11; r = ec;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL glitch_post ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
      if (rdy_a === 1'b1) begin run_e = ec; break; end
    end
    n_checks++;
    if (run_e != r + 2 + STAB_A + HOLD_A) begin
      n_fail++; $display("FAIL glitch_run_edge act=%0d exp=%0d", run_e, r + 2 + STAB_A + HOLD_A);
    end
    n_checks++;
    if (lc_a !== 8'd0) begin n_fail++; $display("FAIL glitch_count act=%0d exp=0", lc_a); end
  endtask

  task automatic test_hold_drop();
    int h = -1, w = -1;
    logic saw_ready = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL hold_pre ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
      if (st_a == 2'b01) begin h = ec; break; end
    end
    n_checks++;
    if (h != 1026) begin n_fail++; $display("FAIL hold_entry act=%0d exp=1026", h); end
    repeat (6) @(negedge clk);
    lk_a[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL hold_drop ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
      if (rdy_a === 1'b1) saw_ready = 1'b1;
      if (st_a == 2'b00 && w < 0) w = ec;
    end
    n_checks++;
    if (w != h + 9) begin n_fail++; $display("FAIL hold_exit_edge act=%0d exp=%0d", w, h + 9); end
    n_checks++;
    if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready act=%b exp=0", saw_ready); end
    n_checks++;
    if (lc_a !== 8'(CE)) begin n_fail++; $display("FAIL hold_count act=%0d exp=%0d", lc_a, CE); end
    lk_a = 2'b11;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL hold_rerun ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
      if (rdy_a === 1'b1) break;
    end
  endtask

  task automatic test_run_drop();
    int d, r, fall_e = -1, pulses = 0, run_e = -1, len;
    len = $urandom_range(2, 6);
    d = ec;
    lk_a[$urandom_range(0, 1)] = 1'b0;
    for (int i = 0; i < len + 6; i++) begin
      if (i == len) lk_a = 2'b11;
      if (i == len) r = ec;
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL run_drop ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
      if (gr_a === 1'b1 && fall_e < 0) fall_e = ec;
      if (ll_a === 1'b1) pulses++;
    end
    n_checks++;
    if (fall_e != d + 3) begin n_fail++; $display("FAIL run_fall_edge act=%0d exp=%0d", fall_e, d + 3); end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL run_pulse_cnt act=%0d exp=1", pulses); end
    n_checks++;
    if (lc_a !== 8'(2 * CE)) begin n_fail++; $display("FAIL run_count act=%0d exp=%0d", lc_a, 2 * CE); end
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL run_rerun ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
      if (rdy_a === 1'b1) begin run_e = ec; break; end
    end
    n_checks++;
    if (run_e != r + 2 + STAB_A + HOLD_A) begin
      n_fail++; $display("FAIL run_reentry act=%0d exp=%0d", run_e, r + 2 + STAB_A + HOLD_A);
    end
  endtask

  task automatic test_rst_mid_run();
    int hold_e = -1, run_e = -1;
    @(negedge clk); #2; rst = 1'b1; #1;
    n_checks++;
    if ({gr_a, rdy_a, st_a, ll_a, lc_a} !== 13'b1_0_00_0_00000000) begin
      n_fail++; $display("FAIL async_rst_a act=%b exp=%b", {gr_a, rdy_a, st_a, ll_a, lc_a}, 13'b1_0_00_0_00000000);
    end
    n_checks++;
    if ({gr_b, rdy_b, st_b, ll_b, lc_b} !== 7'b1_0_00_0_00) begin
      n_fail++; $display("FAIL async_rst_b act=%b exp=%b", {gr_b, rdy_b, st_b, ll_b, lc_b}, 7'b1_0_00_0_00);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL rst_seq ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
      if (st_a == 2'b01 && hold_e < 0) hold_e = ec;
      if (st_a == 2'b10 && run_e < 0) begin run_e = ec; break; end
    end
    n_checks++;
    if (hold_e != 1026 || run_e != 1042) begin
      n_fail++; $display("FAIL rst_reseq act=%0d/%0d exp=1026/1042", hold_e, run_e);
    end
  endtask

  task automatic test_saturate();
    int exp_c;
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); n_checks++;
        if (act_v !== exp_v) begin n_fail++; $display("FAIL sat_wait ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
        if (st_b == 2'b10) break;
      end
      lk_b = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      repeat (4) @(negedge clk);
      exp_c = (CE != 0) ? ((k < 3) ? k : 3) : 0;
      n_checks++;
      if (lc_b !== 2'(exp_c)) begin n_fail++; $display("FAIL sat_count_%0d act=%0d exp=%0d", k, lc_b, exp_c); end
      lk_b = 2'b11;
    end
  endtask

  task automatic test_random();
    int ga = 0, gb = 0;
    for (int i = 0; i < 4000; i++) begin
      if (ga > 0) ga--;
      else if ($urandom_range(0, 1499) == 0) begin ga = $urandom_range(1, 8); lk_a = 2'($urandom_range(0, 2)); end
      else lk_a = 2'b11;
      if (gb > 0) gb--;
      else if ($urandom_range(0, 9) == 0) begin gb = $urandom_range(1, 3); lk_b = 2'($urandom_range(0, 2)); end
      else lk_b = 2'b11;
      @(negedge clk); n_checks++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL random ec=%0d act=%h exp=%h", ec, act_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_wait_glitch();
    test_hold_drop();
    test_run_drop();
    test_rst_mid_run();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
